branch_adder_arbiter: RTL and testbench

- Shares one branch-target adder (PC + shifted offset) between NUM_REQ pipeline requesters in the multi-pipeline core.
- Round-robin arbitration, one grant per cycle.
- Registered single-entry result stage with valid/ready backpressure toward the fetch/PC-select logic.
- Sits between the decode/execute stages of each pipeline and the PC update mux.

---
 rtl/branch_adder_arbiter.sv | 128 ++++++++++++
 tb/tb_branch_adder_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_adder_arbiter.sv
// Shared branch-target adder with round-robin arbitration and a single-entry result register.
// Optional flush ports are enabled by defining BRANCH_ARB_FLUSH_EN.
//
// state | meaning
// EMPTY | result register holds no target
// FULL  | result register holds a target waiting for rsp_ready
module branch_adder_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_pc,
    input  logic [NUM_REQ*WIDTH-1:0] req_offset,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_target,
`ifdef BRANCH_ARB_FLUSH_EN
    input  logic                     flush,
    input  logic [ID_W-1:0]          flush_id,
`endif
    input  logic                     rsp_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_target_q, rsp_target_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] suppress;
    logic               flush_hit;
    logic               can_accept;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [WIDTH-1:0]   sel_pc, sel_off, sum;

`ifdef BRANCH_ARB_FLUSH_EN
    always_comb begin
        suppress = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush && (flush_id == ID_W'(i))) suppress[i] = 1'b1;
        end
        flush_hit = flush && (state_q == FULL) && (rsp_id_q == flush_id);
    end
`else
    assign suppress  = '0;
    assign flush_hit = 1'b0;
`endif

    // A held entry that is being flushed frees the slot just like a consumed one.
    assign can_accept = !reset && ((state_q == EMPTY) || rsp_ready || flush_hit);

    always_comb begin
        int idx;
        idx          = 0;
        grant_onehot = '0;
        grant_id     = '0;
        grant_any    = 1'b0;
        if (can_accept) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grant_any && req_valid[ID_W'(idx)] && !suppress[ID_W'(idx)]) begin
                    grant_any                  = 1'b1;
                    grant_id                   = ID_W'(idx);
                    grant_onehot[ID_W'(idx)]   = 1'b1;
                end
            end
        end
    end

    // One adder; operands are selected by the one-hot grant.
    always_comb begin
        sel_pc  = '0;
        sel_off = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                sel_pc  = sel_pc  | req_pc[i*WIDTH +: WIDTH];
                sel_off = sel_off | req_offset[i*WIDTH +: WIDTH];
            end
        end
        sum = sel_pc + sel_off;
    end

    always_comb begin
        int nxt;
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_target_d = rsp_target_q;
        rr_ptr_d     = rr_ptr_q;
        nxt          = int'(grant_id) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        if (grant_any) begin
            state_d      = FULL;
            rsp_id_d     = grant_id;
            rsp_target_d = sum;
            rr_ptr_d     = ID_W'(nxt);
        end else if ((state_q == FULL) && (rsp_ready || flush_hit)) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            rsp_id_q     <= '0;
            rsp_target_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_target_q <= rsp_target_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign req_ready  = grant_onehot;
    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_target = rsp_target_q;

endmodule

// File: tb/tb_branch_adder_arbiter.sv
// Directed bench for branch_adder_arbiter (default build, NUM_REQ=2, WIDTH=32).
module tb_branch_adder_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_pc;
    logic [63:0] req_offset;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_target;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    branch_adder_arbiter #(.NUM_REQ(2), .WIDTH(32), .ID_W(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_offset (req_offset),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_target (rsp_target),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] pc, input logic [31:0] off);
        req_pc[id*32 +: 32]     = pc;
        req_offset[id*32 +: 32] = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_t [4];

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_pc     = '0;
        req_offset = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_target", 64'(rsp_target), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;

        // single request from 0
        req_valid = 2'b01;
        set_req(0, 32'h0000_1000, 32'h0000_0020);
        rsp_ready = 1'b1;
        #1;
        check("single_ready", 64'(req_ready), 64'b01);
        tick();
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_target", 64'(rsp_target), 64'h0000_1020);

        // requester 1 alone, wrapping add, pass-through while FULL
        req_valid = 2'b10;
        set_req(1, 32'hFFFF_FFFC, 32'h0000_0008);
        #1;
        check("wrap_ready", 64'(req_ready), 64'b10);
        tick();
        check("wrap_id", 64'(rsp_id), 64'd1);
        check("wrap_target", 64'(rsp_target), 64'h0000_0004);

        // contention: pointer is back at 0, grants go 0,1,0,1
        req_valid = 2'b11;
        set_req(0, 32'h0000_0100, 32'h0000_0010);
        set_req(1, 32'h0000_0200, 32'h0000_0004);
        exp_t[0] = 32'h0000_0110;
        exp_t[1] = 32'h0000_0204;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            check("rr_valid", 64'(rsp_valid), 64'd1);
            check("rr_id", 64'(rsp_id), 64'(k % 2));
            check("rr_target", 64'(rsp_target), 64'(exp_t[k % 2]));
        end

        // backpressure with negative offset pending on requester 1
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        set_req(1, 32'h0000_0100, 32'hFFFF_FFF0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'b00);
            tick();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_target", 64'(rsp_target), 64'h0000_0204);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'b10);
        tick();
        check("neg_id", 64'(rsp_id), 64'd1);
        check("neg_target", 64'(rsp_target), 64'h0000_00F0);

        // drain
        req_valid = 2'b00;
        #1;
        check("idle_ready", 64'(req_ready), 64'b00);
        tick();
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // move pointer to 1, hold result, then reset between edges
        req_valid = 2'b01;
        set_req(0, 32'h0000_3000, 32'h0000_0004);
        tick();
        check("pre_rst_target", 64'(rsp_target), 64'h0000_3004);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_target", 64'(rsp_target), 64'd0);
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_req(0, 32'h0000_0010, 32'h0000_0020);
        set_req(1, 32'h0000_0040, 32'h0000_0040);
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b01);
        tick();
        check("post_rst_id", 64'(rsp_id), 64'd0);
        check("post_rst_target", 64'(rsp_target), 64'h0000_0030);

        // idle cycles keep priority at requester 1
        req_valid = 2'b00;
        tick();
        tick();
        check("idle_valid", 64'(rsp_valid), 64'd0);
        req_valid = 2'b11;
        #1;
        check("idle_prio_ready", 64'(req_ready), 64'b10);
        tick();
        check("idle_prio_id", 64'(rsp_id), 64'd1);
        check("idle_prio_target", 64'(rsp_target), 64'h0000_0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
